dmem_sized_ctrl: RTL and testbench

//   Parametrised successor to the single-cycle word data memory of the MIPS datapath.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_sized_ctrl.sv | 140 ++++++++++++++
 tb/tb_dmem_sized_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Access-size codes and controller state encodings shared with the
//            MEM-stage decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Little-endian byte-lane steering for stores and load extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdword,
    input  logic        is_unsigned,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        byte_en   = 4'b0000;
        wword     = wdata;
        rdata_ext = 32'h0000_0000;
        misalign  = 1'b0;
        w_byte    = rdword[8*addr_lo +: 8];
        w_half    = addr_lo[1] ? rdword[31:16] : rdword[15:0];
        case (size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wword     = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                misalign  = addr_lo[0];
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                rdata_ext = rdword;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_sized_ctrl.sv
// ============================================================================
// Module   : dmem_sized_ctrl
// Purpose  : Byte-addressed data memory with sized accesses, programmable
//            response latency and error reporting over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_sized_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int TEST_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [TEST_W-1:0] test_value
);

    localparam int         c_IDX_W  = $clog2(DEPTH);
    localparam logic [2:0] c_LAT_M1 = 3'(LATENCY - 1);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [DEPTH];
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_wword;
    logic [31:0]        w_rdata_ext;
    logic               w_misalign;
    logic               w_out_of_range;
    logic               w_err;

    // Index may wrap for out-of-range addresses; such accesses are blocked by w_err.
    assign w_idx          = r_addr[c_IDX_W+1:2];
    assign w_out_of_range = ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
    assign w_err          = (r_size == SIZE_ILL) | w_misalign | w_out_of_range;

    dmem_lane_align u_lane_align (
        .addr_lo     (r_addr[1:0]),
        .size        (r_size),
        .wdata       (r_wdata),
        .rdword      (r_mem[w_idx]),
        .is_unsigned (r_unsigned),
        .byte_en     (w_byte_en),
        .wword       (w_wword),
        .rdata_ext   (w_rdata_ext),
        .misalign    (w_misalign)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_we        <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    // The access commits here so the pulse, data and memory update land together.
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_err;
                    r_rsp_rdata <= (w_err || r_we) ? 32'h0000_0000 : w_rdata_ext;
                    if (r_we && !w_err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_byte_en[b]) begin
                                r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign test_value = r_mem[0][TEST_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_dmem_sized_ctrl.sv
// ============================================================================
// Module   : tb_dmem_sized_ctrl
// Purpose  : Self-checking bench: vector table plus scoreboard on a LATENCY=3
//            instance, throughput sequences on LATENCY=1 and LATENCY=4 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_sized_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;
    localparam int LAT_C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        rv_a, rv_b, rv_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        er_a, er_b, er_c;
    logic [15:0] tv_a, tv_b, tv_c;

    dmem_sized_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT_A), .TEST_W(16)) u_dut_a (
        .clk(clk), .reset(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(we), .req_size(sz), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(er_a),
        .test_value(tv_a));

    dmem_sized_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT_B), .TEST_W(16)) u_dut_b (
        .clk(clk), .reset(rst_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(we), .req_size(sz), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(er_b),
        .test_value(tv_b));

    dmem_sized_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT_C), .TEST_W(16)) u_dut_c (
        .clk(clk), .reset(rst_n), .req_valid(valid_c), .req_ready(ready_c),
        .req_we(we), .req_size(sz), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv_c), .rsp_rdata(rd_c), .rsp_err(er_c),
        .test_value(tv_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    rsp_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic e);
        vec_t v;
        v.we = w; v.sz = s; v.uns = u; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_err = e;
        return v;
    endfunction

    // Scoreboard: every response of instance A must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rv_a) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%h expected=none", rd_a);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", rd_a, e.rdata);
                chk("rsp_err", {31'b0, er_a}, {31'b0, e.err});
            end
        end
    end

    // Issues one request to A, then scrambles the inputs while it is in flight.
    task automatic do_req(input vec_t v);
        int n;
        n = 0;
        while (!ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, ready_a}, 32'd1);
        we = v.we; sz = v.sz; uns = v.uns; addr = v.addr; wdata = v.wdata;
        valid_a = 1'b1;
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv_a && n < 20);
        // Pulse is high in the cycle after edge N+LATENCY, the (LATENCY+1)-th negedge.
        chk("latency", 32'(n), 32'(LAT_A + 1));
        @(negedge clk);
        chk("rsp_pulse_width", {31'b0, rv_a}, 32'd0);
    endtask

    // Holds valid high on instance B (sel=0) or C (sel=1) and measures accept spacing.
    task automatic thr(input bit sel, input int lat);
        int acc[$];
        int rsp[$];
        int cyc;
        logic rdy, rv;
        cyc = 0;
        we = 1'b1; sz = SIZE_WORD; uns = 1'b0; addr = 32'h0; wdata = 32'h0000_CAFE;
        if (sel) valid_c = 1'b1; else valid_b = 1'b1;
        for (int k = 0; k < 3 * (lat + 1) + 3; k++) begin
            rdy = sel ? ready_c : ready_b;
            rv  = sel ? rv_c : rv_b;
            if (rv) begin
                rsp.push_back(cyc);
                chk("thr_store_rdata", sel ? rd_c : rd_b, 32'h0);
            end
            @(posedge clk);
            cyc++;
            if (rdy) acc.push_back(cyc);
            @(negedge clk);
        end
        valid_b = 1'b0;
        valid_c = 1'b0;
        chk("thr_accept_count", {31'b0, acc.size() >= 3}, 32'd1);
        chk("thr_rsp_count", {31'b0, rsp.size() >= 3}, 32'd1);
        if (acc.size() >= 3 && rsp.size() >= 3) begin
            for (int i = 0; i < 2; i++)
                chk("thr_accept_spacing", 32'(acc[i+1] - acc[i]), 32'(lat + 1));
            for (int i = 0; i < 3; i++)
                chk("thr_rsp_edge", 32'(rsp[i]), 32'(acc[i] + lat));
        end
        repeat (lat + 3) @(negedge clk);
        chk("thr_test_value", {16'h0, sel ? tv_c : tv_b}, 32'h0000_CAFE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        we = 1'b0; sz = SIZE_WORD; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rv_a}, 32'd0);
        chk("reset_rsp_rdata", rd_a, 32'h0);
        chk("reset_rsp_err", {31'b0, er_a}, 32'd0);
        chk("reset_test_value", {16'h0, tv_a}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, ready_a}, 32'd1);

        for (int i = 0; i < DEPTH; i++)
            do_req(mk(1'b0, SIZE_WORD, 1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0));

        // Reset asserted while A is in WAIT aborts the store.
        we = 1'b1; sz = SIZE_WORD; uns = 1'b0; addr = 32'h10; wdata = 32'h1234_5678;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(negedge clk);
        chk("in_wait_ready", {31'b0, ready_a}, 32'd0);
        rst_n = 1'b0;
        repeat (LAT_A + 2) begin
            @(negedge clk);
            chk("rsp_during_reset", {31'b0, rv_a}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (LAT_A + 2) begin
            @(negedge clk);
            chk("rsp_after_abort", {31'b0, rv_a}, 32'd0);
        end
        do_req(mk(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0));

        vecs.push_back(mk(1, SIZE_WORD, 0, 32'h0,   32'hDEAD_BEEF, 32'h0, 0));
        vecs.push_back(mk(0, SIZE_WORD, 1, 32'h0,   32'h0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, SIZE_WORD, 0, 32'h4,   32'h1122_3344, 32'h0, 0));
        vecs.push_back(mk(1, SIZE_BYTE, 0, 32'h6,   32'hFFFF_FFAA, 32'h0, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h4,   32'h0, 32'h11AA_3344, 0));
        vecs.push_back(mk(1, SIZE_HALF, 0, 32'h4,   32'h1234_5566, 32'h0, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h4,   32'h0, 32'h11AA_5566, 0));
        vecs.push_back(mk(0, SIZE_HALF, 1, 32'h6,   32'h0, 32'h0000_11AA, 0));
        vecs.push_back(mk(1, SIZE_WORD, 0, 32'h8,   32'h80FF_7F01, 32'h0, 0));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 32'h9,   32'h0, 32'h0000_007F, 0));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 32'hA,   32'h0, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, SIZE_BYTE, 1, 32'hA,   32'h0, 32'h0000_00FF, 0));
        vecs.push_back(mk(0, SIZE_HALF, 0, 32'hA,   32'h0, 32'hFFFF_80FF, 0));
        vecs.push_back(mk(0, SIZE_HALF, 1, 32'hA,   32'h0, 32'h0000_80FF, 0));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 32'hB,   32'h0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, SIZE_BYTE, 1, 32'hB,   32'h0, 32'h0000_0080, 0));
        vecs.push_back(mk(0, SIZE_HALF, 0, 32'h8,   32'h0, 32'h0000_7F01, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h2,   32'h0, 32'h0, 1));
        vecs.push_back(mk(0, SIZE_HALF, 0, 32'h1,   32'h0, 32'h0, 1));
        vecs.push_back(mk(0, SIZE_ILL,  0, 32'h4,   32'h0, 32'h0, 1));
        vecs.push_back(mk(1, SIZE_WORD, 0, 32'(DEPTH * 4), 32'h0BAD_F00D, 32'h0, 1));
        vecs.push_back(mk(1, SIZE_WORD, 0, 32'h5,   32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(1, SIZE_ILL,  0, 32'h8,   32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h4,   32'h0, 32'h11AA_5566, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h8,   32'h0, 32'h80FF_7F01, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'h0,   32'h0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, SIZE_WORD, 0, 32'(DEPTH * 4 - 4), 32'hA5A5_5A5A, 32'h0, 0));
        vecs.push_back(mk(0, SIZE_WORD, 0, 32'(DEPTH * 4 - 4), 32'h0, 32'hA5A5_5A5A, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            do_req(v);
        end
        chk("test_value", {16'h0, tv_a}, 32'h0000_BEEF);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        thr(1'b0, LAT_B);
        thr(1'b1, LAT_C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
